// File: rtl/axilite_cmd_arbiter.sv
// rtl/axilite_cmd_arbiter.sv - round-robin sequencer sharing one AXI-Lite master command port
// Optional timeout abort in WAIT is enabled by defining AXIL_ARB_TIMEOUT_EN.
module axilite_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [31:0]           req_rdata,
  output logic                  req_err,
  output logic                  busy,
  output logic                  wren,
  output logic                  rden,
  output logic [31:0]           wr_addr,
  output logic [31:0]           wr_data,
  output logic [31:0]           rd_addr,
  input  logic                  wr_done,
  input  logic                  rd_done,
  input  logic [31:0]           rd_data
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic                pick_vld;
  logic                write_q, write_d;
  logic [31:0]         wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [31:0]         rd_addr_q, rd_addr_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  done_q, done_d, gnt_oh;
`ifdef AXIL_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
`endif

  // First requesting index at or above the pointer, wrapping around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && req_valid[j]) begin
        pick     = IW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  assign gnt_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    write_d   = write_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    done_d    = '0;
`ifdef AXIL_ARB_TIMEOUT_EN
    err_d     = 1'b0;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          write_d = req_write[pick];
          if (req_write[pick]) begin
            wr_addr_d = req_addr[32*pick +: 32];
            wr_data_d = req_wdata[32*pick +: 32];
          end else begin
            rd_addr_d = req_addr[32*pick +: 32];
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ptr_d   = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = ST_WAIT;
`ifdef AXIL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        // A done of the other type is deliberately ignored here.
        if (write_q ? wr_done : rd_done) begin
          done_d  = gnt_oh;
          if (!write_q) rdata_d = rd_data;
          state_d = ST_IDLE;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          done_d  = gnt_oh;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      write_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      done_q    <= '0;
`ifdef AXIL_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      write_q   <= write_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
`ifdef AXIL_ARB_TIMEOUT_EN
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign req_ack   = (state_q == ST_ISSUE) ? gnt_oh : '0;
  assign wren      = (state_q == ST_ISSUE) &&  write_q;
  assign rden      = (state_q == ST_ISSUE) && !write_q;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;
  assign req_rdata = rdata_q;
  assign req_done  = done_q;
`ifdef AXIL_ARB_TIMEOUT_EN
  assign req_err   = err_q;
`else
  assign req_err   = 1'b0;
`endif

endmodule

// File: tb/tb_axilite_cmd_arbiter.sv
// tb/tb_axilite_cmd_arbiter.sv - directed self-checking bench for axilite_cmd_arbiter
module tb_axilite_cmd_arbiter;

  localparam int N = 4;

  logic            ACLK = 1'b0;
  logic            ARESETn;
  logic [N-1:0]    req_valid, req_write;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N-1:0]    req_ack, req_done;
  logic [31:0]     req_rdata;
  logic            req_err, busy, wren, rden;
  logic [31:0]     wr_addr, wr_data, rd_addr;
  logic            wr_done, rd_done;
  logic [31:0]     rd_data;

  logic [31:0] a [N];
  logic [31:0] d [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32]  = a[i];
      req_wdata[32*i +: 32] = d[i];
    end
  end

  axilite_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_done(req_done), .req_rdata(req_rdata),
    .req_err(req_err), .busy(busy), .wren(wren), .rden(rden),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .wr_done(wr_done), .rd_done(rd_done), .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Waits for the grant of requester g, acts as the master with latency lat,
  // optionally injecting a done of the wrong type in the first WAIT cycle.
  task automatic serve(input int g, input int lat, input logic [31:0] rdata,
                       input bit drop, input bit wrong);
    int waited = 0;
    bit w;
    while (req_ack == '0 && waited < 20) begin
      tick();
      waited++;
    end
    check("ack_latency", waited, 1);
    check("ack", 32'(req_ack), 32'(1) << g);
    w = req_write[g];
    check("wren", wren, w);
    check("rden", rden, !w);
    check("busy_issue", busy, 1);
    if (w) begin
      check("wr_addr", wr_addr, a[g]);
      check("wr_data", wr_data, d[g]);
    end else begin
      check("rd_addr", rd_addr, a[g]);
    end
    if (drop) req_valid = '0;
    for (int k = 0; k < lat; k++) begin
      tick();
      wr_done = 1'b0;
      rd_done = 1'b0;
      if (wrong && k == 0) begin
        if (w) rd_done = 1'b1;
        else   wr_done = 1'b1;
      end
      check("wait_ack", 32'(req_ack), 0);
      check("wait_done", 32'(req_done), 0);
      check("wait_busy", busy, 1);
    end
    if (w) wr_done = 1'b1;
    else begin
      rd_done = 1'b1;
      rd_data = rdata;
    end
    tick();
    wr_done = 1'b0;
    rd_done = 1'b0;
    rd_data = 32'h0;
    check("done", 32'(req_done), 32'(1) << g);
    check("done_err", req_err, 0);
    check("done_busy", busy, 0);
    if (!w) check("rdata", req_rdata, rdata);
  endtask

  initial begin
    int cnt;
    bit seen;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    ARESETn = 1'b0;
    req_valid = '0; req_write = '0;
    wr_done = 1'b0; rd_done = 1'b0; rd_data = 32'h0;
    for (int i = 0; i < N; i++) begin a[i] = 32'h0; d[i] = 32'h0; end
    repeat (3) tick();
    check("rst_ack", 32'(req_ack), 0);
    check("rst_done", 32'(req_done), 0);
    check("rst_rdata", req_rdata, 0);
    check("rst_err", req_err, 0);
    check("rst_busy", busy, 0);
    check("rst_wren", wren, 0);
    check("rst_rden", rden, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    ARESETn = 1'b1;
    tick();

    a[1] = 32'h0000_0010; d[1] = 32'hA5A5_0001;
    req_write = 4'b0010; req_valid = 4'b0010;
    serve(1, 3, 32'h0, 1'b1, 1'b0);

    a[2] = 32'h0000_0020;
    req_write = 4'b0000; req_valid = 4'b0100;
    serve(2, 2, 32'h1234_5678, 1'b1, 1'b0);

    a[3] = 32'h0000_0030; d[3] = 32'hDEAD_0003;
    req_write = 4'b1000; req_valid = 4'b1000;
    serve(3, 1, 32'h0, 1'b1, 1'b0);
    check("rdata_hold", req_rdata, 32'h1234_5678);

    for (int i = 0; i < N; i++) begin
      a[i] = 32'h100 + 32'(i) * 32'h10;
      d[i] = 32'h5500_0000 + 32'(i);
    end
    req_write = 4'b0101; req_valid = 4'b1111;
    for (int i = 0; i < 6; i++)
      serve(order[i], 1 + (i % 3), 32'hF000_0000 + 32'(i), i == 5, 1'b0);

    a[0] = 32'h0000_0044;
    req_write = 4'b0000; req_valid = 4'b0001;
    serve(0, 3, 32'hBEEF_0044, 1'b1, 1'b1);

    a[3] = 32'h0000_0038;
    req_write = 4'b0000; req_valid = 4'b1000;
    tick();
    check("rst_wait_ack", 32'(req_ack), 32'b1000);
    tick();
    tick();
    ARESETn = 1'b0;
    req_valid = '0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rd_addr", rd_addr, 0);
    check("midrst_rdata", req_rdata, 0);
    check("midrst_rden", rden, 0);
    tick();
    ARESETn = 1'b1;
    rd_done = 1'b1; rd_data = 32'h9999_9999;
    tick();
    rd_done = 1'b0; rd_data = 32'h0;
    check("late_done", 32'(req_done), 0);
    check("late_busy", busy, 0);
    tick();
    check("late_done2", 32'(req_done), 0);

    a[1] = 32'h0000_0050; a[3] = 32'h0000_0058;
    req_write = 4'b0000; req_valid = 4'b1010;
    serve(1, 2, 32'hCAFE_F00D, 1'b1, 1'b0);

    a[2] = 32'h0000_0060; d[2] = 32'h0000_0077;
    req_write = 4'b0100; req_valid = 4'b0100;
    tick();
    check("to_ack", 32'(req_ack), 32'b0100);
    req_valid = '0;
`ifdef AXIL_ARB_TIMEOUT_EN
    cnt = 0;
    while (req_done == '0 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("to_cycles", cnt, 9);
    check("to_done", 32'(req_done), 32'b0100);
    check("to_err", req_err, 1);
    check("to_rdata", req_rdata, 32'hCAFE_F00D);
    tick();
    check("to_err_clear", req_err, 0);
    check("to_busy", busy, 0);
`else
    seen = 1'b0;
    cnt = 0;
    repeat (1000) begin
      tick();
      cnt++;
      if (req_done != '0) seen = 1'b1;
    end
    check("no_to_done", seen, 0);
    check("no_to_busy", busy, 1);
    check("no_to_err", req_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axilite_cmd_arbiter.md
Name: axilite_cmd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one AXI4-Lite master command port (wren/rden pulse, address, data, wr_done/rd_done) between NUM_REQ requesters.
- Sits between the DMA control/status engines and the AXI-Lite master.
- Issues one transaction at a time: grant, issue, wait for completion, return result to the owning requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 256, cycles in WAIT before a timeout abort. Used only with AXIL_ARB_TIMEOUT_EN; range 1..65535.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request; held until req_ack
- req_write  in  NUM_REQ  1=write, 0=read; held with req_valid
- req_addr  in  NUM_REQ*32  flattened addresses; slice i = [32*i+31:32*i]
- req_wdata  in  NUM_REQ*32  flattened write data
- req_ack  out  NUM_REQ  one-hot one-cycle pulse: request accepted, payload captured
- req_done  out  NUM_REQ  one-hot one-cycle pulse: transaction complete
- req_rdata  out  32  read data; valid when req_done pulses for a read
- req_err  out  1  high with req_done on a timeout abort
- busy  out  1  high in ISSUE or WAIT
- wren  out  1  one-cycle write-start pulse to the master
- rden  out  1  one-cycle read-start pulse to the master
- wr_addr  out  32  write address to the master
- wr_data  out  32  write data to the master
- rd_addr  out  32  read address to the master
- wr_done  in  1  write-response handshake from the master
- rd_done  in  1  read complete from the master; rd_data valid in the same cycle
- rd_data  in  32  read data from the master

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE; round-robin pointer is 0; grant index is 0.
- Reset asserted mid-transaction forces all of the above immediately. A done arriving after reset is ignored because state is IDLE.
- Clock and reset are decided: one clock, ACLK; reset ARESETn is asynchronous and active-low.
- States:
  - IDLE: if any req_valid, pick the first set bit searching from the pointer upward with wrap. Register the grant index, req_write, addr and wdata of that requester. Go to ISSUE.
  - ISSUE (1 cycle):
    - Pulse req_ack[gnt].
    - Write: pulse wren and drive wr_addr/wr_data.
    - Read: pulse rden and drive rd_addr.
    - Set pointer to (gnt+1) mod NUM_REQ. Go to WAIT.
  - WAIT:
    - Write grant: on wr_done, pulse req_done[gnt] next cycle and return to IDLE.
    - Read grant: on rd_done, capture rd_data into req_rdata, pulse req_done[gnt] next cycle and return to IDLE.
    - A done of the wrong type is ignored.
  - DONE pulse: issued from registered logic. The cycle after the done input, req_done is high and state is IDLE. A new grant can be evaluated in that same cycle.
- Latency: req_valid sampled at edge N gives req_ack and wren/rden during cycle N+1. Minimum round trip is 3 cycles plus the master latency.
- Address and data outputs hold the last issued value after ISSUE (registered, not cleared).
- req_rdata holds until the next read completes; write completions do not change it.
- wr_done/rd_done are ignored in IDLE and ISSUE.
- Dropping req_valid before req_ack is illegal; the payload captured at grant is used regardless.
- Single requester held valid is re-granted every transaction; the pointer wrap is harmless.
- A requester may re-request on the cycle its req_done pulses; it competes under the updated pointer.

Optional Feature:
- Macro AXIL_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no matching done, pulse req_done[gnt] with req_err=1 and req_rdata unchanged, then return to IDLE.
  - A matching done in the same cycle as the timeout wins, with req_err=0.
- Undefined: no counter; req_err is tied 0; WAIT persists until the matching done.

Test Plan:
- Single write: req_valid=4'b0010, write, addr 32'h0000_0010, data 32'hA5A5_0001. Required: req_ack[1] and wren with wr_addr=0x10, wr_data=0xA5A50001 in the same cycle. wr_done 3 cycles later -> req_done[1] the next cycle, req_err=0, busy falls.
- Single read: req 2 reads 0x20; master returns rd_done with rd_data 0x1234_5678 -> req_done[2] pulses, req_rdata=0x12345678 and held through a later write.
- Fairness: all four requesters held valid continuously -> grant order 0,1,2,3,0,1 with exactly one outstanding transaction at a time.
- Wrong-type done: read granted; wr_done pulse in WAIT -> no req_done. The later rd_done completes normally.
- Reset mid-WAIT: ARESETn low during WAIT -> outputs 0 immediately. rd_done after release is ignored; the next request is granted starting from pointer 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): write with no wr_done -> req_done and req_err=1 exactly 8 WAIT cycles after entry. With the macro undefined -> still waiting after 1000 cycles.
